regfile_rand_writer: RTL and testbench

- Upstream write-port driver for the 2^N x W register bank: generates we / addr_rd / data_in from a 16-bit LFSR.
- FILL phase writes a pseudo-random word into every register 1..2^N-1 in order, then RUN phase keeps writing random words to random addresses at a programmable rate.
- Used on the FPGA board so the bank's read ports always have live, changing contents to display.

---
 rtl/regfile_rand_pkg.sv | 29 ++
 rtl/lfsr16.sv | 25 ++
 rtl/regfile_rand_writer.sv | 150 +++++++++++++++
 tb/tb_regfile_rand_writer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_rand_pkg.sv
// Shared state type, LFSR constants and LFSR helpers for the random
// register-bank writer.
package regfile_rand_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Taps are numbered 16..1 from the MSB; mirroring the register lines them
  // up with the shift-right update, so the feedback is bits 0,2,3,5.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] mirror;
    for (int i = 0; i < 16; i++) begin
      mirror[i] = cur[15 - i];
    end
    return {^(mirror & LFSR_TAPS), cur[15:1]};
  endfunction

  // An all-zero LFSR never leaves zero, so a zero seed falls back to the default.
  function automatic logic [15:0] safe_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with an enable; async reset loads the (guarded) seed.
module lfsr16
  import regfile_rand_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_s;

  assign seed_s = safe_seed(seed);

  // Shift register: advances only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= seed_s;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/regfile_rand_writer.sv
// Write-port driver for a 2^N x W register bank: fills registers 1..2^N-1,
// then keeps writing LFSR data to LFSR-chosen addresses once per slot.
module regfile_rand_writer
  import regfile_rand_pkg::*;
#(
  parameter int          N        = 4,
  parameter int          W        = 8,
  parameter int          TICK_DIV = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  output logic         we,
  output logic [N-1:0] addr_rd,
  output logic [W-1:0] data_in,
  output logic         busy,
  output logic         fill_done,
  output logic [15:0]  wr_count
);

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [N-1:0]  LAST_ADDR  = {N{1'b1}};
  localparam logic [N-1:0]  ZERO_ADDR  = {N{1'b0}};

  state_t        state_r;
  state_t        state_s;
  logic [PW-1:0] presc_r;
  logic [N-1:0]  fill_ptr_r;
  logic [15:0]   lfsr_s;
  logic [N-1:0]  run_addr_s;
  logic [W-1:0]  rand_data_s;
  logic          presc_hit_s;
  logic          tick_s;
  logic          enter_fill_s;
  logic          state_chg_s;

  assign presc_hit_s  = (presc_r == PRESC_LAST);
  assign run_addr_s   = N'(lfsr_s >> (16 - N));
  assign rand_data_s  = W'(lfsr_s);
  assign enter_fill_s = (state_r == IDLE) && (state_s == FILL);
  assign state_chg_s  = (state_s != state_r);

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_s),
    .seed (SEED),
    .q    (lfsr_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and write-slot qualification; stop overrides everything.
  always_comb begin
    state_s = state_r;
    tick_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (stop) begin
          state_s = IDLE;
        end else if (presc_hit_s) begin
          tick_s = 1'b1;
          if (fill_ptr_r == LAST_ADDR) begin
            state_s = RUN;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      RUN: begin
        if (stop) begin
          state_s = IDLE;
        end else begin
          tick_s  = presc_hit_s;
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Slot prescaler: held at zero in IDLE and restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
    end else if (state_chg_s || (state_r == IDLE) || presc_hit_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Write port, fill pointer and status; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_ptr_r <= N'(1);
      we         <= 1'b0;
      addr_rd    <= {N{1'b0}};
      data_in    <= {W{1'b0}};
      busy       <= 1'b0;
      fill_done  <= 1'b0;
      wr_count   <= 16'd0;
    end else begin
      we   <= 1'b0;
      busy <= (state_s != IDLE);
      if (enter_fill_s) begin
        fill_ptr_r <= N'(1);
        fill_done  <= 1'b0;
        wr_count   <= 16'd0;
      end else if (tick_s && (state_r == FILL)) begin
        we         <= 1'b1;
        addr_rd    <= fill_ptr_r;
        data_in    <= rand_data_s;
        wr_count   <= wr_count + 16'd1;
        fill_ptr_r <= fill_ptr_r + N'(1);
        if (fill_ptr_r == LAST_ADDR) begin
          fill_done <= 1'b1;
        end
      end else if (tick_s && (run_addr_s != ZERO_ADDR)) begin
        // Address 0 is reserved: a zero draw burns the slot without writing.
        we       <= 1'b1;
        addr_rd  <= run_addr_s;
        data_in  <= rand_data_s;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_rand_writer.sv
// Bench for regfile_rand_writer: two instances (slot every cycle, slot every
// 4 cycles) against a slot-counting reference model, plus directed checks.
module tb_regfile_rand_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        we1, we4, busy1, busy4, fd1, fd4;
  logic [3:0]  addr1, addr4;
  logic [7:0]  data1, data4;
  logic [15:0] wc1, wc4;

  int n_total;
  int n_bad;
  bit chk_en;

  regfile_rand_writer #(.N(4), .W(8), .TICK_DIV(1), .SEED(16'hACE1)) d1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .we(we1), .addr_rd(addr1), .data_in(data1),
    .busy(busy1), .fill_done(fd1), .wr_count(wc1)
  );

  regfile_rand_writer #(.N(4), .W(8), .TICK_DIV(4), .SEED(16'hACE1)) d4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .we(we4), .addr_rd(addr4), .data_in(data4),
    .busy(busy4), .fill_done(fd4), .wr_count(wc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // LFSR step straight from the update rule.
  function automatic int lfsr_step(input int v);
    int fb;
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return (fb << 15) | ((v & 32'hFFFF) >> 1);
  endfunction

  // Reference model: phase 0 idle, 1 fill, 2 run; slot counts cycles since entry.
  int m_phase[2], m_slot[2], m_ptr[2], m_lf[2];
  int m_we[2], m_addr[2], m_data[2], m_busy[2], m_fd[2], m_wc[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_slot[k] = 0; m_ptr[k] = 1; m_lf[k] = 32'hACE1;
      m_we[k] = 0; m_addr[k] = 0; m_data[k] = 0;
      m_busy[k] = 0; m_fd[k] = 0; m_wc[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int div);
    int a;
    m_we[k] = 0;
    if (m_phase[k] == 0) begin
      if (start && !stop) begin
        m_phase[k] = 1; m_slot[k] = 0; m_ptr[k] = 1; m_fd[k] = 0; m_wc[k] = 0;
      end
    end else if (stop) begin
      m_phase[k] = 0;
    end else begin
      m_slot[k]++;
      if (m_slot[k] == div) begin
        m_slot[k] = 0;
        a = (m_phase[k] == 1) ? m_ptr[k] : (m_lf[k] >> 12);
        if (a != 0) begin
          m_we[k] = 1; m_addr[k] = a; m_data[k] = m_lf[k] & 255;
          m_wc[k] = (m_wc[k] + 1) % 65536;
        end
        m_lf[k] = lfsr_step(m_lf[k]);
        if (m_phase[k] == 1) begin
          if (m_ptr[k] == 15) begin
            m_fd[k] = 1;
            m_phase[k] = 2;
          end
          m_ptr[k]++;
        end
      end
    end
    m_busy[k] = (m_phase[k] != 0) ? 1 : 0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, 1);
      model_step(1, 4);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d1_we", we1, m_we[0]);        chk("d1_addr", addr1, m_addr[0]);
      chk("d1_data", data1, m_data[0]);  chk("d1_busy", busy1, m_busy[0]);
      chk("d1_fill_done", fd1, m_fd[0]); chk("d1_wr_count", wc1, m_wc[0]);
      chk("d4_we", we4, m_we[1]);        chk("d4_addr", addr4, m_addr[1]);
      chk("d4_data", data4, m_data[1]);  chk("d4_busy", busy4, m_busy[1]);
      chk("d4_fill_done", fd4, m_fd[1]); chk("d4_wr_count", wc4, m_wc[1]);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, we1, 0);      chk({tag, "_addr"}, addr1, 0);
    chk({tag, "_data"}, data1, 0);  chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_fd"}, fd1, 0);      chk({tag, "_wc"}, wc1, 0);
    chk({tag, "_we4"}, we4, 0);     chk({tag, "_wc4"}, wc4, 0);
  endtask

  int bank[16];
  int first_data[3];
  int w1, w4, last4, prev, skips, v;

  initial begin
    n_total = 0; n_bad = 0; chk_en = 1'b0;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    first_data[0] = 32'hE1; first_data[1] = 32'h70; first_data[2] = 32'h38;
    for (int i = 0; i < 16; i++) bank[i] = 0;

    // Asynchronous reset seen before any clock edge.
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // FILL: sequence, done flag, bank contents, TICK_DIV=4 spacing.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fill_busy", busy1, 1);
    chk("fill_wc0", wc1, 0);
    w1 = 0; w4 = 0; last4 = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (we1) begin
        if (w1 < 15) begin
          bank[addr1] = data1;
          chk("fill_addr", addr1, w1 + 1);
          chk("fill_done_at", fd1, (w1 == 14) ? 1 : 0);
          if (w1 < 3) chk("fill_data", data1, first_data[w1]);
        end
        w1++;
      end
      if (we4) begin
        if (w4 < 3) chk("tick4_gap", c - last4, 4);
        last4 = c;
        w4++;
      end
    end
    chk("fill_writes", (w1 >= 15) ? 1 : 0, 1);
    chk("fill_writes4", (w4 >= 15) ? 1 : 0, 1);
    chk("fill_done_sticky", fd1, 1);
    chk("bank0", bank[0], 0);
    v = 32'hACE1;
    for (int i = 1; i < 16; i++) begin
      chk("bank", bank[i], v & 255);
      v = lfsr_step(v);
    end

    // RUN: nonzero addresses, zero draws burn a slot; start is ignored.
    prev = wc1; skips = 0;
    repeat (200) begin
      @(negedge clk);
      if (we1) chk("run_addr_nz", (addr1 != 4'd0) ? 1 : 0, 1);
      else begin
        chk("skip_wc_hold", wc1, prev);
        skips++;
      end
      prev = wc1;
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk("skip_seen", (skips > 0) ? 1 : 0, 1);
    chk("run_fd_kept", fd1, 1);

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", busy1, 0);
    chk("stop_fd_kept", fd1, 1);

    // Restart, then stop mid-FILL with fill_ptr at 6.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_wc", wc1, 0);
    chk("restart_fd", fd1, 0);
    @(negedge clk);
    chk("restart_addr", addr1, 1);
    chk("restart_wc1", wc1, 1);
    repeat (4) @(negedge clk);
    chk("mid_addr", addr1, 5);
    chk("mid_wc", wc1, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("mid_stop_we", we1, 0);
    chk("mid_stop_busy", busy1, 0);
    chk("mid_stop_wc", wc1, 5);

    // stop wins over start in IDLE.
    start = 1'b1; stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("prec_busy", busy1, 0);
      chk("prec_busy4", busy4, 0);
    end
    start = 1'b0; stop = 1'b0;

    // Reset during RUN.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_busy", busy1, 1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_run");
    chk("rst_lfsr", d1.u_lfsr.q, 32'hACE1);
    chk("rst_lfsr4", d4.u_lfsr.q, 32'hACE1);
    @(negedge clk);
    rst = 1'b0;

    // Random start/stop traffic.
    repeat (1500) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 63) == 0);
    end
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
